// File: rtl/vga_scan_scheduler.sv
// Raster sequencer: h/v counters, sync/blank decode and one next-line prefetch request per line.
// Define VGA_SCHED_UNDERRUN_CNT_EN to implement the saturating underrun counter.
module vga_scan_scheduler #(
   parameter int unsigned H_DISPLAY       = 640,
   parameter int unsigned H_FRONT         = 16,
   parameter int unsigned H_SYNC          = 96,
   parameter int unsigned H_BACK          = 48,
   parameter int unsigned V_DISPLAY       = 480,
   parameter int unsigned V_FRONT         = 10,
   parameter int unsigned V_SYNC          = 2,
   parameter int unsigned V_BACK          = 33,
   parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame,
   output logic       fetch_req,
   output logic [9:0] fetch_line,
   input  logic       fetch_ack,
   output logic       underrun,
   output logic [7:0] underrun_count
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [10:0] V_VIS_W = 11'(V_DISPLAY);

   // XOR with this turns an active-high decode into the configured pin polarity.
   localparam logic SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

   typedef enum logic {StIdle, StReq} state_e;

   state_e     state_q, state_d;
   logic [9:0] hpos_q, hpos_d;
   logic [9:0] vpos_q, vpos_d;
   logic [7:0] frame_q, frame_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       display_on_q, display_on_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;
   logic [9:0] fetch_line_q, fetch_line_d;
   logic       underrun_q, underrun_d;
   logic       line_end, frame_end;
   logic       next_visible, req_start;

   // Counters and timing decode; decode uses the next count so it lines up with it.
   always_comb begin
      line_end  = (hpos_q == H_LAST);
      frame_end = line_end && (vpos_q == V_LAST);
      hpos_d    = line_end ? '0 : hpos_q + 10'd1;
      vpos_d    = vpos_q;
      if (line_end) begin
         vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
      end
      frame_d       = frame_end ? frame_q + 8'd1 : frame_q;
      hsync_d       = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ^ SYNC_OFF;
      vsync_d       = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ^ SYNC_OFF;
      display_on_d  = (hpos_d < H_VIS) && (vpos_d < V_VIS);
      line_start_d  = (hpos_d == '0);
      frame_start_d = (hpos_d == '0) && (vpos_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hpos_q        <= '0;
         vpos_q        <= '0;
         frame_q       <= '0;
         hsync_q       <= SYNC_OFF;
         vsync_q       <= SYNC_OFF;
         display_on_q  <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         frame_q       <= frame_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_on_q  <= display_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Fetch FSM: state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         fetch_line_q <= '0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_line_q <= fetch_line_d;
         underrun_q   <= underrun_d;
      end
   end

   // Fetch FSM: next state. The request is raised on the edge that presents hpos == H_DISPLAY,
   // so fetch_req shows up in that same cycle; the last line of the frame prefetches line 0.
   always_comb begin
      next_visible = (({1'b0, vpos_q} + 11'd1) < V_VIS_W) || (vpos_q == V_LAST);
      req_start    = (hpos_d == H_VIS) && next_visible;
      state_d      = state_q;
      fetch_line_d = fetch_line_q;
      underrun_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_start) begin
               state_d      = StReq;
               fetch_line_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
            end
         end
         StReq: begin
            if (fetch_ack) begin
               state_d = StIdle;
            end else if (line_end) begin
               state_d    = StIdle;
               underrun_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Fetch FSM: outputs.
   always_comb begin
      fetch_req = (state_q == StReq);
   end

`ifdef VGA_SCHED_UNDERRUN_CNT_EN
   logic [7:0] underrun_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         underrun_count_q <= '0;
      end else if (underrun_d && (underrun_count_q != 8'hFF)) begin
         underrun_count_q <= underrun_count_q + 8'd1;
      end
   end

   assign underrun_count = underrun_count_q;
`else
   assign underrun_count = '0;
`endif

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign frame       = frame_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = display_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign fetch_line  = fetch_line_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_scan_scheduler.sv
// Directed bench: full-size 640x480 timing for line-level checks, plus a tiny raster
// (16x12, active-high sync) for frame-level and underrun-saturation checks.
module tb_vga_scan_scheduler;

`ifdef VGA_SCHED_UNDERRUN_CNT_EN
   localparam int CNT_EN = 1;
`else
   localparam int CNT_EN = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_a = 1'b1, reset_b = 1'b1;
   logic       ack_a = 1'b1, ack_b = 1'b1;

   logic [9:0] hpos_a, vpos_a, fetch_line_a, hpos_b, vpos_b, fetch_line_b;
   logic [7:0] frame_a, underrun_count_a, frame_b, underrun_count_b;
   logic       hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a, fetch_req_a;
   logic       underrun_a;
   logic       hsync_b, vsync_b, display_on_b, line_start_b, frame_start_b, fetch_req_b;
   logic       underrun_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vga_scan_scheduler u_dut_a (
      .clk            (clk),
      .reset          (reset_a),
      .hpos           (hpos_a),
      .vpos           (vpos_a),
      .hsync          (hsync_a),
      .vsync          (vsync_a),
      .display_on     (display_on_a),
      .line_start     (line_start_a),
      .frame_start    (frame_start_a),
      .frame          (frame_a),
      .fetch_req      (fetch_req_a),
      .fetch_line     (fetch_line_a),
      .fetch_ack      (ack_a),
      .underrun       (underrun_a),
      .underrun_count (underrun_count_a)
   );

   vga_scan_scheduler #(
      .H_DISPLAY       (8),
      .H_FRONT         (2),
      .H_SYNC          (3),
      .H_BACK          (3),
      .V_DISPLAY       (6),
      .V_FRONT         (2),
      .V_SYNC          (2),
      .V_BACK          (2),
      .SYNC_ACTIVE_LOW (0)
   ) u_dut_b (
      .clk            (clk),
      .reset          (reset_b),
      .hpos           (hpos_b),
      .vpos           (vpos_b),
      .hsync          (hsync_b),
      .vsync          (vsync_b),
      .display_on     (display_on_b),
      .line_start     (line_start_b),
      .frame_start    (frame_start_b),
      .frame          (frame_b),
      .fetch_req      (fetch_req_b),
      .fetch_line     (fetch_line_b),
      .fetch_ack      (ack_b),
      .underrun       (underrun_b),
      .underrun_count (underrun_count_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int h, v;
      int lo_cnt, lo_first, lo_last, rq_cnt, rq_first, rq_last, rq_line, ur_n, ur_h;
      int hs_bad, vs_bad, de_bad, pos_bad, ls_cnt, fs_cnt, fs_frame, req_bad, cnt_mid;
      logic [11:0] req_mask;

      // ---------------- Full-size raster ----------------
      repeat (3) tick();
      reset_a = 1'b0;
      check("a_rst_hpos", hpos_a, 0);
      check("a_rst_vpos", vpos_a, 0);
      check("a_rst_hsync", hsync_a, 1);
      check("a_rst_vsync", vsync_a, 1);
      check("a_rst_de", display_on_a, 0);
      check("a_rst_req", fetch_req_a, 0);
      check("a_rst_ucnt", underrun_count_a, 0);

      tick();
      h = 1; v = 0;
      check("a_first_hpos", hpos_a, 1);
      check("a_first_vpos", vpos_a, 0);
      check("a_first_de", display_on_a, 1);
      check("a_first_req", fetch_req_a, 0);

      // Line 0 with ack tied high.
      lo_cnt = 0; lo_first = -1; lo_last = -1; rq_cnt = 0; rq_first = -1; rq_line = -1; ur_n = 0;
      for (int i = 0; i < 799; i++) begin
         tick();
         h = (h + 1) % 800;
         if (h == 0) v++;
         if (hsync_a == 1'b0) begin
            lo_cnt++;
            if (lo_first < 0) lo_first = h;
            lo_last = h;
         end
         if (fetch_req_a) begin
            rq_cnt++;
            rq_first = h;
            rq_line = int'(fetch_line_a);
         end
         if (underrun_a) ur_n++;
      end
      check("a_wrap_hpos", hpos_a, 0);
      check("a_wrap_vpos", vpos_a, 1);
      check("a_wrap_ls", line_start_a, 1);
      check("a_wrap_fs", frame_start_a, 0);
      check("a_hs_cnt", lo_cnt, 96);
      check("a_hs_first", lo_first, 656);
      check("a_hs_last", lo_last, 751);
      check("a_req_cnt", rq_cnt, 1);
      check("a_req_h", rq_first, 640);
      check("a_req_line", rq_line, 1);
      check("a_ur_none", ur_n, 0);

      // Line 1 unacked: request expires at end of line.
      ack_a = 1'b0;
      rq_cnt = 0; rq_first = -1; rq_last = -1; ur_n = 0; ur_h = -1;
      for (int i = 0; i < 800; i++) begin
         tick();
         h = (h + 1) % 800;
         if (h == 0) v++;
         if (fetch_req_a) begin
            rq_cnt++;
            if (rq_first < 0) rq_first = h;
            rq_last = h;
         end
         if (underrun_a) begin
            ur_n++;
            ur_h = h;
         end
      end
      check("a_ur_req_first", rq_first, 640);
      check("a_ur_req_last", rq_last, 799);
      check("a_ur_req_cnt", rq_cnt, 160);
      check("a_ur_pulses", ur_n, 1);
      check("a_ur_at_h0", ur_h, 0);
      check("a_ur_vpos", vpos_a, 2);
      check("a_ur_count", underrun_count_a, (CNT_EN != 0) ? 1 : 0);

      // Line 2: stray ack while idle, then ack only in the final cycle.
      rq_first = -1;
      for (int i = 0; i < 799; i++) begin
         tick();
         h = (h + 1) % 800;
         if (fetch_req_a && rq_first < 0) rq_first = h;
         ack_a = (h == 100);
      end
      check("a_late_req_held", fetch_req_a, 1);
      check("a_late_req_first", rq_first, 640);
      ack_a = 1'b1;
      tick();
      ack_a = 1'b0;
      check("a_late_hpos", hpos_a, 0);
      check("a_late_req_low", fetch_req_a, 0);
      check("a_late_no_ur", underrun_a, 0);
      check("a_late_count", underrun_count_a, (CNT_EN != 0) ? 1 : 0);

      // Line 3: reset while the request is pending.
      repeat (700) tick();
      check("a_mid_hpos", hpos_a, 700);
      check("a_mid_req", fetch_req_a, 1);
      check("a_mid_line", fetch_line_a, 4);
      reset_a = 1'b1;
      tick();
      reset_a = 1'b0;
      check("a_mrst_req", fetch_req_a, 0);
      check("a_mrst_hpos", hpos_a, 0);
      check("a_mrst_vpos", vpos_a, 0);
      check("a_mrst_ucnt", underrun_count_a, 0);
      check("a_mrst_ur", underrun_a, 0);

      // ---------------- Tiny raster: 16 x 12, active-high sync ----------------
      reset_b = 1'b1;
      repeat (2) tick();
      reset_b = 1'b0;
      check("b_rst_hsync", hsync_b, 0);
      check("b_rst_vsync", vsync_b, 0);
      check("b_rst_frame", frame_b, 0);
      h = 0; v = 0;
      hs_bad = 0; vs_bad = 0; de_bad = 0; pos_bad = 0; ls_cnt = 0; fs_cnt = 0; fs_frame = -1;
      req_bad = 0; rq_cnt = 0; ur_n = 0; req_mask = '0;
      for (int i = 0; i < 384; i++) begin
         tick();
         h = (h + 1) % 16;
         if (h == 0) v = (v + 1) % 12;
         if (int'(hpos_b) != h || int'(vpos_b) != v) pos_bad++;
         if (hsync_b != (h >= 10 && h <= 12)) hs_bad++;
         if (vsync_b != (v >= 8 && v <= 9)) vs_bad++;
         if (display_on_b != (h < 8 && v < 6)) de_bad++;
         if (line_start_b) ls_cnt++;
         if (frame_start_b) begin
            fs_cnt++;
            if (fs_frame < 0) fs_frame = int'(frame_b);
         end
         if (fetch_req_b) begin
            rq_cnt++;
            req_mask[v] = 1'b1;
            if (h != 8 || int'(fetch_line_b) != ((v == 11) ? 0 : v + 1)) req_bad++;
         end
         if (underrun_b) ur_n++;
      end
      check("b_pos", pos_bad, 0);
      check("b_hsync", hs_bad, 0);
      check("b_vsync", vs_bad, 0);
      check("b_de", de_bad, 0);
      check("b_ls_cnt", ls_cnt, 24);
      check("b_fs_cnt", fs_cnt, 2);
      check("b_fs_frame", fs_frame, 1);
      check("b_frame", frame_b, 2);
      check("b_req_mask", req_mask, 12'h81F);
      check("b_req_cnt", rq_cnt, 12);
      check("b_req_bad", req_bad, 0);
      check("b_ur_none", ur_n, 0);

      // 50 frames unacked: 6 requests per frame expire -> 300 underruns.
      ack_b = 1'b0;
      ur_n = 0; rq_cnt = 0; cnt_mid = -1;
      for (int i = 1; i <= 9600; i++) begin
         tick();
         if (underrun_b) ur_n++;
         if (fetch_req_b) rq_cnt++;
         if (i == 192) cnt_mid = int'(underrun_count_b);
      end
      check("b_ur_pulses", ur_n, 300);
      check("b_ur_req_cycles", rq_cnt, 2400);
      check("b_ucnt_mid", cnt_mid, (CNT_EN != 0) ? 6 : 0);
      check("b_ucnt_sat", underrun_count_b, (CNT_EN != 0) ? 255 : 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_scan_scheduler.md
Name: vga_scan_scheduler

Overview:
- Master raster sequencer for the VGA playground: owns horizontal/vertical counters, generates sync/blank timing, and schedules one per-line prefetch of pixel data for the next visible scanline via a req/ack handshake.
- Sits between the top-level wrapper and the pixel-generation datapath. Pixel generators consume hpos/vpos/display_on; a line-buffer fill engine answers fetch_req.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync low during the pulse; 0 = high
- Derived: H_TOTAL = sum of the four H values (800); V_TOTAL = sum of the four V values (525).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hpos  out  10  current horizontal position, 0..H_TOTAL-1
- vpos  out  10  current vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync; polarity set by SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync; polarity set by SYNC_ACTIVE_LOW
- display_on  out  1  high when hpos < H_DISPLAY and vpos < V_DISPLAY
- line_start  out  1  one-cycle pulse when hpos == 0
- frame_start  out  1  one-cycle pulse when hpos == 0 and vpos == 0
- frame  out  8  frame counter, wraps 255 -> 0
- fetch_req  out  1  prefetch request for the line given on fetch_line
- fetch_line  out  10  visible line index to prefetch; stable while fetch_req is high
- fetch_ack  in  1  fetch engine accepts the request
- underrun  out  1  one-cycle pulse when a request expires unacked
- underrun_count  out  8  saturating count of underruns (see Optional Feature)

Behaviour:
- Reset (sampled at the clock edge), all outputs are registered:
  - hpos = 0, vpos = 0, frame = 0, underrun_count = 0.
  - hsync and vsync at their inactive level.
  - display_on, line_start, frame_start, fetch_req, underrun all = 0; fetch_line = 0.
  - The FSM returns to IDLE, even mid-request.
- Counters:
  - hpos increments every cycle; after H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps V_TOTAL-1 -> 0; frame increments on that same edge.
  - The first cycle after reset deasserts shows hpos = 1, vpos = 0. Pixel (0,0) of the first frame is blanked.
- Timing decode:
  - hsync, vsync, display_on, line_start and frame_start are computed from the next counter value and registered, so they describe the hpos/vpos presented in the same cycle (zero skew, no pipeline offset).
  - hsync is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - vsync is active for vpos in [490, 491].
- Fetch FSM, states IDLE and REQ:
  - IDLE -> REQ at hpos == H_DISPLAY when the next line is visible: vpos+1 < V_DISPLAY, or vpos == V_TOTAL-1 (which prefetches line 0).
  - On entry to REQ: fetch_req = 1 and fetch_line = next line index (vpos+1, or 0 on the wrap case).
  - REQ with fetch_ack = 1 at an edge -> IDLE; fetch_req falls the following cycle.
  - REQ still unacked at the edge ending hpos == H_TOTAL-1 -> IDLE; underrun pulses 1 cycle; underrun_count increments, saturating at 255.
  - fetch_ack sampled in that final cycle counts as success: no underrun.
  - fetch_ack while IDLE is ignored.
  - At most one request per line. No request is issued on lines 479..523 (next line not visible).

Optional Feature:
- Macro: VGA_SCHED_UNDERRUN_CNT_EN.
- Defined: underrun_count is implemented as described above.
- Undefined: the counter register is omitted and underrun_count is tied to 0. The underrun pulse is unaffected.

Test Plan:
- Reset held 3 cycles, then released -> hpos=1, vpos=0, display_on=1, fetch_req=0; after 799 further cycles hpos=0, vpos=1, line_start=1.
- Free-run with SYNC_ACTIVE_LOW=1 -> hsync=0 exactly for hpos 656..751; vsync=0 exactly on lines 490..491; frame_start once per 420000 cycles; frame increments 0 -> 1.
- fetch_ack tied 1 -> fetch_req high for 1 cycle starting at hpos=640 on vpos 0..478 (fetch_line = vpos+1) and on vpos 524 (fetch_line = 0); no req on vpos 479..523; underrun never pulses.
- fetch_ack tied 0 for one line -> req held from hpos 640 to 799; underrun pulses in the cycle after hpos 799; underrun_count = 1.
- fetch_ack asserted only at hpos=799 -> request accepted; no underrun; fetch_req low at hpos=0.
- Reset asserted while fetch_req=1 at hpos 700 -> next cycle fetch_req=0, hpos=0, vpos=0, underrun_count=0.
- Macro undefined: 300 forced underruns -> underrun_count stays 0. Macro defined: underrun_count saturates at 255.
